// File: rtl/ofdm_seq_pkg.sv
// rtl/ofdm_seq_pkg.sv - shared types and sizing helpers for the OFDM burst sequencer
//
// Contents:
//   seq_state_e     burst sequencer FSM states
//   NFFT_DEFAULT    default FFT length in samples
//   CP_LEN_DEFAULT  default cyclic prefix length in samples
//   SYM_LEN         samples per OFDM symbol for the default geometry
//   cnt_width()     smallest counter width that can hold a full burst
package ofdm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_DONE
  } seq_state_e;

  localparam int NFFT_DEFAULT   = 4096;
  localparam int CP_LEN_DEFAULT = 256;
  localparam int SYM_LEN        = NFFT_DEFAULT + CP_LEN_DEFAULT;

  // 2^w must strictly exceed the largest burst, hence the +1.
  function automatic int cnt_width(input int max_symbols, input int sym_len);
    return $clog2(max_symbols * sym_len + 1);
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// rtl/axis_beat_counter.sv - stream beat counter with last-beat compare
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          synchronous clear, wins over beat_i
//   beat_i         one accepted handshake this cycle
//   total_i        number of beats in the frame
//   last_o         high while the next accepted beat is beat total_i-1
module axis_beat_counter #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         beat_i,
  input  logic [W-1:0] total_i,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (beat_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == total_i - 1'b1);

endmodule

// File: rtl/ofdm_burst_sequencer.sv
// rtl/ofdm_burst_sequencer.sv - frame-level TX/RX burst controller for the DUC/DDC chain
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   start, abort                  one-cycle commands (abort wins)
//   cfg_*                         run configuration sampled on an accepted start
//   Fc_scaled .. i_shift_reg      latched static config to the datapath
//   src_* -> duc_*                IFFT samples passed to the DUC during TX, tlast generated here
//   ddc_* -> rx_*                 DDC samples passed to the host during RX, tlast generated here
//   busy, done, err               status: not idle, completion pulse, sticky cfg error
module ofdm_burst_sequencer
  import ofdm_seq_pkg::*;
#(
  parameter int NFFT          = NFFT_DEFAULT,
  parameter int CP_LEN        = CP_LEN_DEFAULT,
  parameter int MAX_SYMBOLS   = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = cnt_width(MAX_SYMBOLS, NFFT + CP_LEN)
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_num_symbols,
  input  logic [31:0] cfg_fc_scaled,
  input  logic [15:0] cfg_ratio,
  input  logic [2:0]  cfg_shift,
  input  logic [15:0] cfg_rx_delay,
  output logic [31:0] Fc_scaled,
  output logic [15:0] Interp_ratio,
  output logic [15:0] decimate_ratio,
  output logic [2:0]  i_shift_reg,
  input  logic [31:0] src_tdata,
  input  logic        src_tvalid,
  output logic        src_tready,
  output logic [31:0] duc_tdata,
  output logic        duc_tvalid,
  input  logic        duc_tready,
  output logic        duc_tlast,
  output logic [3:0]  duc_tkeep,
  input  logic [31:0] ddc_tdata,
  input  logic        ddc_tvalid,
  output logic        ddc_tready,
  output logic [31:0] rx_tdata,
  output logic        rx_tvalid,
  input  logic        rx_tready,
  output logic        rx_tlast,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int              SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]      MAX_SYM_L   = 8'(MAX_SYMBOLS);
  localparam logic [CNT_W-1:0] SYM_LEN_L  = CNT_W'(NFFT + CP_LEN);

  seq_state_e       state_q, state_d;
  logic [31:0]      fc_q;
  logic [15:0]      ratio_q;
  logic [2:0]       shift_q;
  logic [15:0]      rx_delay_q;
  logic [CNT_W-1:0] total_q;
  logic             err_q, err_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [15:0]      wait_q, wait_d;
  logic             latch;

  logic cfg_legal;
  logic tx_beat, rx_beat, tx_last, rx_last;
  logic [15:0] wait_last;

  assign cfg_legal = (cfg_num_symbols != 8'd0) && (cfg_num_symbols <= MAX_SYM_L);
  assign tx_beat   = (state_q == ST_TX) && src_tvalid && duc_tready;
  assign rx_beat   = (state_q == ST_RX) && ddc_tvalid && rx_tready;
  // A programmed delay of 0 still spends one cycle in WAIT.
  assign wait_last = (rx_delay_q == 16'd0) ? 16'd0 : rx_delay_q - 16'd1;

  axis_beat_counter #(.W(CNT_W)) u_tx_cnt (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .clr_i   ((state_q != ST_TX) || abort),
    .beat_i  (tx_beat),
    .total_i (total_q),
    .last_o  (tx_last)
  );

  axis_beat_counter #(.W(CNT_W)) u_rx_cnt (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .clr_i   ((state_q != ST_RX) || abort),
    .beat_i  (rx_beat),
    .total_i (total_q),
    .last_o  (rx_last)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    latch    = 1'b0;
    settle_d = '0;
    wait_d   = '0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              latch   = 1'b1;
              err_d   = 1'b0;
              state_d = ST_SETTLE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = ST_TX;
          end
        end
        ST_TX: begin
          if (tx_beat && tx_last) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_d = wait_q + 16'd1;
          if (wait_q == wait_last) begin
            wait_d  = '0;
            state_d = ST_RX;
          end
        end
        ST_RX: begin
          if (rx_beat && rx_last) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      settle_q   <= '0;
      wait_q     <= '0;
      fc_q       <= '0;
      ratio_q    <= '0;
      shift_q    <= 3'd2;
      rx_delay_q <= '0;
      total_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      if (latch) begin
        fc_q       <= cfg_fc_scaled;
        ratio_q    <= cfg_ratio;
        shift_q    <= cfg_shift;
        rx_delay_q <= cfg_rx_delay;
        total_q    <= CNT_W'(cfg_num_symbols) * SYM_LEN_L;
      end
    end
  end

  // Stream muxing: DDC is drained (tready=1) in every state except RX so
  // the chain never stalls; outside TX/RX all stream outputs sit at zero.
  always_comb begin
    src_tready = 1'b0;
    duc_tvalid = 1'b0;
    duc_tdata  = '0;
    duc_tkeep  = '0;
    duc_tlast  = 1'b0;
    ddc_tready = 1'b1;
    rx_tvalid  = 1'b0;
    rx_tdata   = '0;
    rx_tlast   = 1'b0;
    case (state_q)
      ST_TX: begin
        src_tready = duc_tready;
        duc_tvalid = src_tvalid;
        duc_tdata  = src_tdata;
        duc_tkeep  = 4'hF;
        duc_tlast  = tx_last;
      end
      ST_RX: begin
        ddc_tready = rx_tready;
        rx_tvalid  = ddc_tvalid;
        rx_tdata   = ddc_tdata;
        rx_tlast   = rx_last;
      end
      default: begin
      end
    endcase
  end

  assign Fc_scaled      = fc_q;
  assign Interp_ratio   = ratio_q;
  assign decimate_ratio = ratio_q;
  assign i_shift_reg    = shift_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;

endmodule

// File: tb/tb_ofdm_burst_sequencer.sv
// tb/tb_ofdm_burst_sequencer.sv - self-checking bench for ofdm_burst_sequencer
module tb_ofdm_burst_sequencer;

  localparam int SYM    = 4096 + 256;
  localparam int SETTLE = 64;
  localparam int P_IDLE = 0, P_SETTLE = 1, P_TX = 2, P_WAIT = 3, P_RX = 4, P_DONE = 5;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, abort;
  logic [7:0]  cfg_num_symbols;
  logic [31:0] cfg_fc_scaled;
  logic [15:0] cfg_ratio;
  logic [2:0]  cfg_shift;
  logic [15:0] cfg_rx_delay;
  logic [31:0] Fc_scaled;
  logic [15:0] Interp_ratio, decimate_ratio;
  logic [2:0]  i_shift_reg;
  logic [31:0] src_tdata, duc_tdata, ddc_tdata, rx_tdata;
  logic        src_tvalid, src_tready;
  logic        duc_tvalid, duc_tready, duc_tlast;
  logic [3:0]  duc_tkeep;
  logic        ddc_tvalid, ddc_tready;
  logic        rx_tvalid, rx_tready, rx_tlast;
  logic        busy, done, err;

  ofdm_burst_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_num_symbols(cfg_num_symbols), .cfg_fc_scaled(cfg_fc_scaled),
    .cfg_ratio(cfg_ratio), .cfg_shift(cfg_shift), .cfg_rx_delay(cfg_rx_delay),
    .Fc_scaled(Fc_scaled), .Interp_ratio(Interp_ratio),
    .decimate_ratio(decimate_ratio), .i_shift_reg(i_shift_reg),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .duc_tdata(duc_tdata), .duc_tvalid(duc_tvalid), .duc_tready(duc_tready),
    .duc_tlast(duc_tlast), .duc_tkeep(duc_tkeep),
    .ddc_tdata(ddc_tdata), .ddc_tvalid(ddc_tvalid), .ddc_tready(ddc_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_tlast(rx_tlast), .busy(busy), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_fc;
  logic [15:0] m_ratio;
  logic [2:0]  m_shift;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_fc"}, Fc_scaled, 32'h0);
    chk({p, "_interp"}, 32'(Interp_ratio), 32'h0);
    chk({p, "_decim"}, 32'(decimate_ratio), 32'h0);
    chk({p, "_shift"}, 32'(i_shift_reg), 32'h2);
    chk({p, "_busy"}, 32'(busy), 32'h0);
    chk({p, "_done"}, 32'(done), 32'h0);
    chk({p, "_err"}, 32'(err), 32'h0);
    chk({p, "_src_tready"}, 32'(src_tready), 32'h0);
    chk({p, "_duc_tvalid"}, 32'(duc_tvalid), 32'h0);
    chk({p, "_duc_tlast"}, 32'(duc_tlast), 32'h0);
    chk({p, "_rx_tvalid"}, 32'(rx_tvalid), 32'h0);
    chk({p, "_rx_tlast"}, 32'(rx_tlast), 32'h0);
    chk({p, "_ddc_tready"}, 32'(ddc_tready), 32'h1);
    m_fc = 32'h0; m_ratio = 16'h0; m_shift = 3'd2;
  endtask

  // Runs one burst against a cycle-level phase model of the sequencer.
  // abort_at / stray_at / reset_at < 0 disable that event.
  task automatic run_burst(input string tag, input int nsym, input logic [31:0] fc,
                           input logic [15:0] ratio, input logic [2:0] shift,
                           input logic [15:0] delay, input bit bp, input int abort_at,
                           input int stray_at, input int reset_at);
    int total, txn, rxn, phase, pcnt, cyc, dones, last_tx, first_rx, eff;
    int hs_err, data_err, last_err, cfg_err;
    bit stray_done, aborted, reset_hit, beat;
    bit [31:0] srcq[$];
    total = nsym * SYM;
    eff = (delay == 16'd0) ? 1 : int'(delay);
    for (int i = 0; i < total; i++) srcq.push_back($urandom);
    txn = 0; rxn = 0; pcnt = 0; cyc = 0; dones = 0; last_tx = 0; first_rx = 0;
    hs_err = 0; data_err = 0; last_err = 0; cfg_err = 0;
    stray_done = 0; aborted = 0; reset_hit = 0;

    @(negedge aclk);
    cfg_num_symbols = 8'(nsym); cfg_fc_scaled = fc; cfg_ratio = ratio;
    cfg_shift = shift; cfg_rx_delay = delay; start = 1'b1; abort = 1'b0;
    @(negedge aclk);
    start = 1'b0;
    m_fc = fc; m_ratio = ratio; m_shift = shift;
    #1;
    chk({tag, "_latch_fc"}, Fc_scaled, fc);
    chk({tag, "_latch_ratio"}, {Interp_ratio, decimate_ratio}, {ratio, ratio});
    chk({tag, "_latch_shift"}, 32'(i_shift_reg), 32'(shift));
    chk({tag, "_busy_after_start"}, 32'(busy), 32'h1);
    chk({tag, "_err_after_start"}, 32'(err), 32'h0);
    phase = P_SETTLE;

    while (phase != P_IDLE && cyc < 40000) begin
      start = 1'b0; abort = 1'b0;
      src_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_tdata  = (txn < total) ? srcq[txn] : $urandom;
      duc_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      ddc_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      ddc_tdata  = $urandom;
      rx_tready  = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (phase == P_TX && txn == abort_at) abort = 1'b1;
      if (phase == P_TX && txn == stray_at && !stray_done) begin
        start = 1'b1; cfg_fc_scaled = ~fc; cfg_num_symbols = 8'd3; stray_done = 1;
      end
      #1;
      if (phase == P_RX && rxn == reset_at) begin
        aresetn = 1'b0;
        #1;
        check_reset_vals({tag, "_async_rst"});
        reset_hit = 1;
        phase = P_IDLE;
        @(negedge aclk);
        aresetn = 1'b1;
      end else begin
        if (src_tready !== ((phase == P_TX) ? duc_tready : 1'b0)) hs_err++;
        if (duc_tvalid !== ((phase == P_TX) ? src_tvalid : 1'b0)) hs_err++;
        if (phase == P_TX && (duc_tdata !== srcq[txn] || duc_tkeep !== 4'hF)) data_err++;
        if (ddc_tready !== ((phase == P_RX) ? rx_tready : 1'b1)) hs_err++;
        if (rx_tvalid !== ((phase == P_RX) ? ddc_tvalid : 1'b0)) hs_err++;
        if (phase == P_RX && rx_tdata !== ddc_tdata) data_err++;
        if (busy !== 1'b1 || err !== 1'b0) hs_err++;
        if (done !== (phase == P_DONE)) hs_err++;
        if (Fc_scaled !== m_fc || Interp_ratio !== m_ratio ||
            decimate_ratio !== m_ratio || i_shift_reg !== m_shift) cfg_err++;
        if (abort) begin
          aborted = 1;
          phase = P_IDLE;
        end else begin
          case (phase)
            P_SETTLE: begin
              pcnt++;
              if (pcnt == SETTLE) phase = P_TX;
            end
            P_TX: begin
              beat = src_tvalid && duc_tready;
              if (beat) begin
                if (duc_tlast !== (txn == total - 1)) last_err++;
                txn++; last_tx = cyc;
                if (txn == total) begin phase = P_WAIT; pcnt = 0; end
              end
            end
            P_WAIT: begin
              pcnt++;
              if (pcnt == eff) phase = P_RX;
            end
            P_RX: begin
              beat = ddc_tvalid && rx_tready;
              if (beat) begin
                if (rx_tlast !== (rxn == total - 1)) last_err++;
                if (rxn == 0) first_rx = cyc;
                rxn++;
                if (rxn == total) phase = P_DONE;
              end
            end
            P_DONE: begin
              dones++;
              phase = P_IDLE;
            end
            default: phase = P_IDLE;
          endcase
        end
        cyc++;
        @(negedge aclk);
      end
    end

    chk({tag, "_handshake_errs"}, hs_err, 0);
    chk({tag, "_data_errs"}, data_err, 0);
    chk({tag, "_tlast_errs"}, last_err, 0);
    chk({tag, "_cfg_stable_errs"}, cfg_err, 0);
    abort = 1'b0; start = 1'b0;
    #1;
    if (abort_at >= 0) begin
      chk({tag, "_abort_tx_beats"}, txn, abort_at);
      chk({tag, "_abort_busy"}, 32'(busy), 32'h0);
      chk({tag, "_abort_src_tready"}, 32'(src_tready), 32'h0);
      chk({tag, "_abort_duc_tvalid"}, 32'(duc_tvalid), 32'h0);
      chk({tag, "_abort_no_done"}, 32'(done), 32'h0);
    end else if (reset_at >= 0) begin
      chk({tag, "_rx_beats_before_reset"}, rxn, reset_at);
      chk({tag, "_idle_after_reset"}, 32'(busy), 32'h0);
    end else begin
      chk({tag, "_tx_beats"}, txn, total);
      chk({tag, "_rx_beats"}, rxn, total);
      chk({tag, "_done_pulses"}, dones, 1);
      chk({tag, "_busy_after_done"}, {31'b0, busy}, 32'h0);
      chk({tag, "_done_after_done"}, {31'b0, done}, 32'h0);
      if (!bp) chk({tag, "_rx_gap"}, first_rx - last_tx, eff + 1);
    end
  endtask

  task automatic illegal_start(input string tag, input logic [7:0] nsym);
    @(negedge aclk);
    cfg_num_symbols = nsym; cfg_fc_scaled = $urandom; cfg_ratio = 16'h1234;
    cfg_shift = 3'd7; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    #1;
    chk({tag, "_err"}, 32'(err), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_fc_unchanged"}, Fc_scaled, m_fc);
    chk({tag, "_ratio_unchanged"}, 32'(Interp_ratio), 32'(m_ratio));
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_num_symbols = 8'd0; cfg_fc_scaled = '0; cfg_ratio = '0; cfg_shift = '0;
    cfg_rx_delay = '0; src_tdata = '0; src_tvalid = 1'b0; duc_tready = 1'b0;
    ddc_tdata = '0; ddc_tvalid = 1'b0; rx_tready = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    check_reset_vals("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // 250 kHz at 100 MHz: 2^32 * 0.0025
    run_burst("legal", 1, 32'h00A3_D70A, 16'd40, 3'd3, 16'd100, 1'b0, -1, -1, -1);
    run_burst("bp", 1, $urandom, 16'd8, 3'd1, 16'd0, 1'b1, -1, -1, -1);

    illegal_start("illegal0", 8'd0);
    illegal_start("illegal17", 8'd17);

    // Largest legal burst is accepted and clears err; abort it straight away.
    @(negedge aclk);
    cfg_num_symbols = 8'd16; cfg_fc_scaled = 32'h0BAD_F00D; cfg_ratio = 16'd25;
    cfg_shift = 3'd4; start = 1'b1;
    @(negedge aclk);
    start = 1'b0; m_fc = 32'h0BAD_F00D; m_ratio = 16'd25; m_shift = 3'd4;
    #1;
    chk("max_sym_err_cleared", 32'(err), 32'h0);
    chk("max_sym_busy", 32'(busy), 32'h1);
    @(negedge aclk);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    #1;
    chk("max_sym_abort_idle", 32'(busy), 32'h0);

    run_burst("abort_tx", 1, 32'h1357_9BDF, 16'd16, 3'd2, 16'd10, 1'b0, 1000, -1, -1);
    run_burst("after_abort", 1, 32'h2468_ACE0, 16'd32, 3'd5, 16'd0, 1'b0, -1, 500, -1);

    // start and abort together in IDLE: abort wins, nothing latched
    @(negedge aclk);
    cfg_num_symbols = 8'd1; cfg_fc_scaled = 32'hFFFF_0000; cfg_ratio = 16'd99;
    start = 1'b1; abort = 1'b1;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_busy", 32'(busy), 32'h0);
    chk("start_abort_fc", Fc_scaled, m_fc);

    run_burst("rst_rx", 1, 32'h0F0F_0F0F, 16'd12, 3'd6, 16'd20, 1'b0, -1, -1, 200);
    @(negedge aclk);
    #1;
    chk("post_reset_shift", 32'(i_shift_reg), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ofdm_burst_sequencer.md
Name: ofdm_burst_sequencer

Overview:
Frame-level controller for the DUC/DDC chain. On a start command it latches the run configuration and drives the chain's static config inputs: carrier word, interpolation/decimation ratios and gain shift. It then streams exactly num_symbols*(NFFT+CP_LEN) IFFT samples into the DUC with a generated tlast, waits a programmable loop latency, and captures the same number of DDC samples toward the host. Sits between the OFDM sample source/sink and the DUC_DDC datapath in the 100 MHz aclk domain.

Parameters:
NFFT, 4096, FFT length in samples
CP_LEN, 256, cyclic prefix length in samples
MAX_SYMBOLS, 16, maximum symbols per burst
SETTLE_CYCLES, 64, aclk cycles config is held stable before TX starts
CNT_W, 17, sample counter width; must satisfy 2^CNT_W > MAX_SYMBOLS*(NFFT+CP_LEN)

Ports:
aclk  in  1  system clock, 100 MHz
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; honoured only in IDLE
abort  in  1  one-cycle abort; returns to IDLE from any state
cfg_num_symbols  in  8  symbols in burst; 0 or >MAX_SYMBOLS is illegal
cfg_fc_scaled  in  32  carrier phase increment
cfg_ratio  in  16  interpolation = decimation ratio
cfg_shift  in  3  DDC gain shift
cfg_rx_delay  in  16  aclk cycles from last TX beat to RX enable
Fc_scaled  out  32  latched carrier word to datapath
Interp_ratio  out  16  latched ratio
decimate_ratio  out  16  latched ratio (same value)
i_shift_reg  out  3  latched shift
src_tdata/src_tvalid/src_tready  in/in/out  32/1/1  IFFT sample source, I=[15:0], Q=[31:16]
duc_tdata/duc_tvalid/duc_tready/duc_tlast/duc_tkeep  out/out/in/out/out  32/1/1/1/4  to DUC S_AXIS
ddc_tdata/ddc_tvalid/ddc_tready  in/in/out  32/1/1  from DDC M_AXIS
rx_tdata/rx_tvalid/rx_tready/rx_tlast  out/out/in/out  32/1/1/1  captured samples to host
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on burst completion
err  out  1  sticky cfg-error flag, cleared by the next accepted legal start

Behaviour:
- Reset values: all config outputs 0, i_shift_reg 3'd2; busy=0, done=0, err=0; state IDLE; counters 0.
- States: IDLE, SETTLE, TX, WAIT, RX, DONE.
- IDLE: start with a legal cfg latches all cfg_* and sets err=0. Config outputs change the next cycle. Then go to SETTLE.
- IDLE: start with an illegal cfg_num_symbols sets err=1 and stays in IDLE.
- Config outputs stay constant from latch until the next accepted start. Abort does not change them.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to TX.
- TX: combinational passthrough. duc_tvalid = src_tvalid; src_tready = duc_tready; duc_tdata = src_tdata; duc_tkeep = 4'hF.
- TX: tx_cnt increments on each src_tvalid&&duc_tready beat. duc_tlast=1 when tx_cnt == total-1.
- TX: when that last beat is accepted, go to WAIT. total = num_symbols*(NFFT+CP_LEN).
- Outside TX: src_tready=0 and duc_tvalid=0. Zero bubble cycles are inserted inside TX.
- WAIT: counts cfg_rx_delay cycles; a delay of 0 means 1 cycle. ddc_tready=1 here and DDC beats are discarded (flushes chain).
- RX: rx_tvalid = ddc_tvalid; ddc_tready = rx_tready; rx_tdata = ddc_tdata.
- RX: rx_cnt counts beats. rx_tlast=1 on beat total-1. After that beat, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- IDLE/SETTLE: ddc_tready=1 (discard) so the DDC never backpressures.
- abort in any state: next state IDLE, counters cleared, no done pulse. An in-flight TX frame is truncated with no tlast.
- start and abort in the same cycle: abort wins.
- start outside IDLE: ignored.
- Reset mid-burst: all outputs return to reset values immediately (async).
- Counters are unsigned CNT_W bits. total is computed once at latch (8-bit x 13-bit multiply, registered).

Decomposition:
- Package ofdm_seq_pkg: state enum, NFFT/CP_LEN defaults, SYM_LEN=NFFT+CP_LEN, CNT_W function.
- Sub-module: axis_beat_counter (count, last-beat compare, clear), instantiated for TX and for RX.

Test Plan:
- Legal burst: num_symbols=1, ratio=40, fc=250 kHz word, rx_delay=100, sinks always ready -> exactly 4352 DUC beats with tlast on beat 4351; 4352 RX beats with rx_tlast on the last; one done pulse; busy falls the same cycle as done.
- Backpressure: random duc_tready/rx_tready at 50% -> beat counts and data order unchanged; no beat lost or duplicated; tlast still on beat 4351.
- Illegal cfg: start with num_symbols=0, then 17 -> err=1, busy stays 0, config outputs unchanged. A following legal start clears err.
- Abort in TX after 1000 beats -> IDLE next cycle, src_tready=0, no done. A new start runs a full 4352-beat burst.
- Start during busy and start+abort same cycle -> ignored / abort wins; latched Fc_scaled unchanged.
- Async reset mid-RX -> all outputs at reset values without a clock edge; i_shift_reg=2.
